mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
Streaming MIPS instruction encoder. It is the inverse of the control-unit decode path: it takes mnemonic and field tuples over a valid/ready handshake and packs them into 32-bit instruction words. Each legal word is emitted with a sequential instruction-memory write address. It sits between a test/program-load source and the instruction memory, so the single-cycle core's program can be built from symbolic fields.

Parameters:
ADDR_W, 6, instruction-memory word-address width; depth = 2^ADDR_W words.
BASE_ADDR, 0, first word address after reset or start; width ADDR_W.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse: clear pointer/errors, enter RUN.
in_valid  input  1  input tuple valid.
in_ready  output  1  encoder accepts the tuple this cycle.
in_op  input  4  mnemonic: 0 lw, 1 sw, 2 add, 3 sub, 4 and, 5 or, 6 slt, 7 addi, 8 beq, 9 j, 10 mul (optional), 11-15 illegal.
in_rs, in_rt, in_rd  input  5 each  register fields.
in_imm  input  16  immediate / branch offset.
in_target  input  26  jump target field.
in_last  input  1  marks the final tuple of a program.
out_valid  output  1  out_instr/out_addr valid.
out_ready  input  1  memory loader takes the word.
out_instr  output  32  encoded instruction.
out_addr  output  ADDR_W  word address for out_instr.
count  output  ADDR_W+1  number of words emitted since start/reset.
err_illegal  output  1  sticky: an illegal op was accepted.
done  output  1  high in DONE state.

Behaviour:
- Reset: state=IDLE; out_valid=0, out_instr=0, out_addr=BASE_ADDR, count=0, err_illegal=0, done=0, in_ready=0. Reset overrides everything, including mid-transfer; a pending word is dropped.
- States:
  - IDLE: start -> RUN.
  - RUN: accepting tuples.
  - DRAIN: the last word is held; wait until it is taken.
  - DONE: done=1; start -> RUN.
- start in any state clears the pointer to BASE_ADDR, count=0, err_illegal=0, out_valid=0, and enters RUN.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Legal op: out_instr/out_addr are registered; out_valid=1 the next cycle (latency 1). The pointer increments by 1 and wraps never (see full).
- Illegal op: the tuple is consumed and nothing is emitted. err_illegal is set the next cycle. The pointer is unchanged.
- out_valid && out_ready: the word is retired and count increments. If accept happens in the same cycle, out_valid stays 1 with the new word (full throughput, 1 word/cycle).
- Transition to DRAIN when either condition holds:
  - an accepted tuple has in_last=1 (legal or illegal);
  - an accepted legal word lands at address 2^ADDR_W-1 (memory full).
- DRAIN -> DONE once out_valid=0, or in the cycle the held word is taken.
- Encodings (fields in MIPS positions; shamt=0):
  - lw: op 100011, rs, rt, imm.
  - sw: op 101011, rs, rt, imm.
  - R-type: op 000000, rs, rt, rd; funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - addi: op 001000, rs, rt, imm.
  - beq: op 000100, rs, rt, imm.
  - j: op 000010, target.
- Unused input fields are ignored. For example, in_rd is ignored for lw.
- out_instr and out_addr hold stable while out_valid && !out_ready.

Optional Feature:
ENC_MUL_EN: when defined, in_op=10 encodes mul as R-type op 000000, funct 011100 (matching the core's ALU decoder). When undefined, in_op=10 is illegal: the tuple is consumed and err_illegal is set.

Test Plan:
- reset, start, then add rs=1 rt=2 rd=3 with out_ready=1 -> next cycle out_valid=1, out_instr=0x00221820, out_addr=0.
- Back-to-back sequence: lw rs=1 rt=2 imm=4; sw rs=0 rt=2 imm=8; beq rs=1 rt=2 imm=0xFFFF; j target=0x10 (in_last) -> words 0x8C220004, 0xAC020008, 0x1022FFFF, 0x08000010 at addresses 0-3 on consecutive cycles; done=1 afterwards; count=4.
- Backpressure: hold out_ready=0 for 3 cycles after the first word -> in_ready=0, out_instr stable; release -> no loss or duplication.
- Illegal op 12 between two adds -> err_illegal=1; only 2 words emitted, at addresses 0 and 1.
- ADDR_W=2: send 5 legal tuples -> 4 words (addresses 0-3), then DONE; the 5th is not accepted (in_ready=0). start -> out_addr restarts at 0.
- mul rs=1 rt=2 rd=3: with ENC_MUL_EN -> 0x0022181C; without it -> no word, err_illegal=1.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS instruction encoder: packs mnemonic/field tuples into 32-bit words with sequential addresses.
// Optional feature macro: ENC_MUL_EN (in_op=10 encodes R-type mul, funct 011100; otherwise illegal).
module mips_instr_encoder #(
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              enc_legal;
  logic [31:0]       enc_word;
  logic              accept, retire, last_slot;

  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign last_slot = (ptr == '1);
  assign done      = (state == DONE);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (in_op)
      4'd0:  enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd1:  enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd2:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd3:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd4:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      4'd5:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      4'd6:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      4'd7:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      4'd8:  enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd9:  enc_word = {6'b000010, in_target};
`ifdef ENC_MUL_EN
      4'd10: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b011100};
`endif
      default: enc_legal = 1'b0;
    endcase
  end

  // start is applied in the register block, so next-state only covers the stream flow.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept && (in_last || (enc_legal && last_slot))) state_nxt = DRAIN;
      DRAIN:   if (!out_valid || retire) state_nxt = DONE;
      default: state_nxt = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_addr    <= BASE_ADDR;
      ptr         <= BASE_ADDR;
      count       <= '0;
      err_illegal <= 1'b0;
    end else if (start) begin
      state       <= RUN;
      out_valid   <= 1'b0;
      out_addr    <= BASE_ADDR;
      ptr         <= BASE_ADDR;
      count       <= '0;
      err_illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      // A new word replaces the retiring one in the same cycle for full throughput.
      if (accept && enc_legal) begin
        out_valid <= 1'b1;
        out_instr <= enc_word;
        out_addr  <= ptr;
        ptr       <= ptr + ADDR_W'(1);
      end else if (retire) begin
        out_valid <= 1'b0;
      end
      if (retire) count <= count + (ADDR_W+1)'(1);
      if (accept && !enc_legal) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized streams against a field-arithmetic model.
module tb_mips_instr_encoder;

  localparam int AW  = 6;
  localparam int AW2 = 2;
`ifdef ENC_MUL_EN
  localparam bit          MUL_EN       = 1'b1;
  localparam bit          EXP_MUL_VLD  = 1'b1;
  localparam bit          EXP_MUL_ERR  = 1'b0;
  localparam logic [31:0] EXP_MUL_WORD = 32'h0022181C;
`else
  localparam bit          MUL_EN       = 1'b0;
  localparam bit          EXP_MUL_VLD  = 1'b0;
  localparam bit          EXP_MUL_ERR  = 1'b1;
  localparam logic [31:0] EXP_MUL_WORD = 32'h0;
`endif

  localparam int OPC_TAB [11] = '{35, 43, 0, 0, 0, 0, 0, 8, 4, 2, 0};
  localparam int FN_TAB  [11] = '{0, 0, 32, 34, 36, 37, 42, 0, 0, 0, 28};

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
  } tuple_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, in_valid, in_last, out_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_ready, out_valid, err_illegal, done;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic [AW:0]   count;

  logic           s_in_ready, s_out_valid, s_err, s_done;
  logic [31:0]    s_out_instr;
  logic [AW2-1:0] s_out_addr;
  logic [AW2:0]   s_count;

  int checks   = 0;
  int failures = 0;
  tuple_t tq[$];

  mips_instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .count(count), .err_illegal(err_illegal), .done(done)
  );

  mips_instr_encoder #(.ADDR_W(AW2)) dut_small (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_instr(s_out_instr), .out_addr(s_out_addr), .count(s_count), .err_illegal(s_err), .done(s_done)
  );

  function automatic bit ref_legal(input logic [3:0] op);
    return (op <= 4'd9) || (op == 4'd10 && MUL_EN);
  endfunction

  // Word = opcode*2^26 + rs*2^21 + rt*2^16 + (rd*2^11 + funct | imm), or opcode*2^26 + target for j.
  function automatic logic [31:0] ref_encode(input tuple_t t);
    longint w;
    int     k;
    bit     is_r;
    k    = int'(t.op);
    is_r = (k >= 2 && k <= 6) || k == 10;
    w    = longint'(OPC_TAB[k]) * 64'd67108864;
    if (k == 9) w += longint'(t.tgt);
    else begin
      w += longint'(t.rs) * 2097152 + longint'(t.rt) * 65536;
      if (is_r) w += longint'(t.rd) * 2048 + longint'(FN_TAB[k]);
      else      w += longint'(t.imm);
    end
    return w[31:0];
  endfunction

  function automatic tuple_t mk(input int op, input int rs, input int rt, input int rd,
                                input int imm, input int tgt, input bit last);
    tuple_t t;
    t.op = 4'(op); t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.imm = 16'(imm); t.tgt = 26'(tgt); t.last = last;
    return t;
  endfunction

  function automatic tuple_t rand_tuple(input int max_op);
    return mk($urandom_range(max_op), $urandom_range(31), $urandom_range(31), $urandom_range(31),
              $urandom_range(65535), $urandom, 1'b0);
  endfunction

  task automatic drive(input tuple_t t, input bit v);
    in_valid = v; in_op = t.op; in_rs = t.rs; in_rt = t.rt; in_rd = t.rd;
    in_imm = t.imm; in_target = t.tgt; in_last = t.last;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Plays tq through the main DUT with random valid/ready gaps, scoring every output against the model.
  task automatic run_stream(input string tag, input int vld_pct, input int rdy_pct, output int retired);
    logic [31:0]   exp_i[$];
    logic [AW-1:0] exp_a[$];
    tuple_t cur;
    int addr = 0, budget = 0;
    bit have = 0, ended = 0, err = 0, exp_rdy;
    retired = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0);
    while (((have || tq.size() != 0) && !ended) || exp_i.size() != 0) begin
      @(posedge clk); #1;
      if (!have && !ended && tq.size() != 0 && $urandom_range(99) < vld_pct) begin
        cur  = tq.pop_front();
        have = 1;
      end
      drive(cur, have && !ended);
      out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      exp_rdy = !ended && (exp_i.size() == 0 || out_ready);
      checks++;
      if (out_valid !== (exp_i.size() != 0)) begin
        failures++; $display("FAIL %s out_valid: got %b want %b", tag, out_valid, exp_i.size() != 0);
      end
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL %s in_ready: got %b want %b", tag, in_ready, exp_rdy);
      end
      if (out_valid && exp_i.size() != 0) begin
        checks += 2;
        if (out_instr !== exp_i[0]) begin
          failures++; $display("FAIL %s out_instr: got %h want %h", tag, out_instr, exp_i[0]);
        end
        if (out_addr !== exp_a[0]) begin
          failures++; $display("FAIL %s out_addr: got %0d want %0d", tag, out_addr, exp_a[0]);
        end
        if (out_ready) begin
          void'(exp_i.pop_front()); void'(exp_a.pop_front()); retired++;
        end
      end
      if (in_valid && in_ready) begin
        have = 0;
        if (ref_legal(cur.op)) begin
          exp_i.push_back(ref_encode(cur));
          exp_a.push_back(AW'(addr));
          addr++;
          if (addr == (1 << AW)) ended = 1;
        end else err = 1;
        if (cur.last) ended = 1;
      end
      budget++;
      if (budget > 3000) begin
        failures++; $display("FAIL %s timeout: got %0d cycles want <= 3000", tag, budget);
        break;
      end
    end
    tq.delete();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (done !== ended) begin
      failures++; $display("FAIL %s done: got %b want %b", tag, done, ended);
    end
    if (count !== (AW+1)'(retired)) begin
      failures++; $display("FAIL %s count: got %0d want %0d", tag, count, retired);
    end
    if (err_illegal !== err) begin
      failures++; $display("FAIL %s err_illegal: got %b want %b", tag, err_illegal, err);
    end
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL %s final out_valid: got %b want 0", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    if (out_instr !== 32'h0)  begin failures++; $display("FAIL reset out_instr: got %h want 0", out_instr); end
    if (out_addr !== '0)      begin failures++; $display("FAIL reset out_addr: got %0d want 0", out_addr); end
    if (count !== '0)         begin failures++; $display("FAIL reset count: got %0d want 0", count); end
    if (err_illegal !== 1'b0) begin failures++; $display("FAIL reset err_illegal: got %b want 0", err_illegal); end
    if (done !== 1'b0)        begin failures++; $display("FAIL reset done: got %b want 0", done); end
    if (in_ready !== 1'b0)    begin failures++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_add();
    do_start();
    @(posedge clk); #1;
    drive(mk(2, 1, 2, 3, 0, 0, 0), 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL add in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1)        begin failures++; $display("FAIL add out_valid: got %b want 1", out_valid); end
    if (out_instr !== 32'h00221820) begin failures++; $display("FAIL add out_instr: got %h want 00221820", out_instr); end
    if (out_addr !== '0)           begin failures++; $display("FAIL add out_addr: got %0d want 0", out_addr); end
  endtask

  task automatic test_back_to_back();
    tuple_t      t[4];
    logic [31:0] w[4];
    t[0] = mk(0, 1, 2, 0, 4, 0, 0);
    t[1] = mk(1, 0, 2, 0, 8, 0, 0);
    t[2] = mk(8, 1, 2, 0, 16'hFFFF, 0, 0);
    t[3] = mk(9, 0, 0, 0, 0, 26'h10, 1);
    w[0] = 32'h8C220004; w[1] = 32'hAC020008; w[2] = 32'h1022FFFF; w[3] = 32'h08000010;
    do_start();
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) drive(t[k], 1'b1);
      else in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b in_ready[%0d]: got %b want 1", k, in_ready); end
      end
      if (k > 0) begin
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b out_valid[%0d]: got %b want 1", k-1, out_valid); end
        if (out_instr !== w[k-1]) begin failures++; $display("FAIL b2b out_instr[%0d]: got %h want %h", k-1, out_instr, w[k-1]); end
        if (out_addr !== AW'(k-1)) begin failures++; $display("FAIL b2b out_addr[%0d]: got %0d want %0d", k-1, out_addr, k-1); end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 3;
    if (done !== 1'b1)      begin failures++; $display("FAIL b2b done: got %b want 1", done); end
    if (count !== 7'd4)     begin failures++; $display("FAIL b2b count: got %0d want 4", count); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b out_valid end: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    tuple_t      t0, t1;
    logic [31:0] e0, e1;
    t0 = mk(2, $urandom_range(31), $urandom_range(31), $urandom_range(31), 0, 0, 0);
    t1 = mk(3, $urandom_range(31), $urandom_range(31), $urandom_range(31), 0, 0, 1);
    e0 = ref_encode(t0); e1 = ref_encode(t1);
    do_start();
    @(posedge clk); #1;
    drive(t0, 1'b1); out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    drive(t1, 1'b1); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp out_valid[%0d]: got %b want 1", c, out_valid); end
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp in_ready[%0d]: got %b want 0", c, in_ready); end
      if (out_instr !== e0)   begin failures++; $display("FAIL bp hold instr[%0d]: got %h want %h", c, out_instr, e0); end
      if (out_addr !== '0)    begin failures++; $display("FAIL bp hold addr[%0d]: got %0d want 0", c, out_addr); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (out_instr !== e0)  begin failures++; $display("FAIL bp release instr: got %h want %h", out_instr, e0); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1)  begin failures++; $display("FAIL bp second valid: got %b want 1", out_valid); end
    if (out_instr !== e1)    begin failures++; $display("FAIL bp second instr: got %h want %h", out_instr, e1); end
    if (out_addr !== AW'(1)) begin failures++; $display("FAIL bp second addr: got %0d want 1", out_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 2;
    if (count !== 7'd2)     begin failures++; $display("FAIL bp count: got %0d want 2", count); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp drained: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    int n;
    do_start();
    tq.push_back(mk(2, 1, 2, 3, 0, 0, 0));
    tq.push_back(mk(12, 4, 5, 6, 7, 8, 0));
    tq.push_back(mk(2, 7, 8, 9, 0, 0, 1));
    run_stream("illegal", 100, 100, n);
    checks += 2;
    if (n !== 2)              begin failures++; $display("FAIL illegal words: got %0d want 2", n); end
    if (err_illegal !== 1'b1) begin failures++; $display("FAIL illegal sticky: got %b want 1", err_illegal); end
  endtask

  task automatic test_mul();
    do_start();
    @(posedge clk); #1;
    drive(mk(10, 1, 2, 3, 0, 0, 1), 1'b1); out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks += 3;
    if (out_valid !== EXP_MUL_VLD) begin failures++; $display("FAIL mul out_valid: got %b want %b", out_valid, EXP_MUL_VLD); end
    if (err_illegal !== EXP_MUL_ERR) begin failures++; $display("FAIL mul err_illegal: got %b want %b", err_illegal, EXP_MUL_ERR); end
    if ((out_valid ? out_instr : 32'h0) !== EXP_MUL_WORD) begin
      failures++; $display("FAIL mul out_instr: got %h want %h", out_instr, EXP_MUL_WORD);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL mul done: got %b want 1", done); end
  endtask

  task automatic test_random();
    int n, len;
    tuple_t t;
    for (int s = 0; s < 8; s++) begin
      do_start();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        t = rand_tuple((s % 2 == 0) ? 15 : 10);
        t.last = (i == len - 1);
        tq.push_back(t);
      end
      run_stream("random", $urandom_range(40, 100), $urandom_range(30, 100), n);
    end
  endtask

  task automatic test_full();
    int acc = 0, seen = 0;
    do_start();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      drive(mk(2, 1, 2, acc, 0, 0, 0), acc < 5);
      out_ready = 1'b1;
      @(negedge clk);
      if (s_out_valid) begin
        checks++;
        if (s_out_addr !== AW2'(seen)) begin failures++; $display("FAIL full addr: got %0d want %0d", s_out_addr, seen); end
        seen++;
      end
      if (in_valid && s_in_ready) acc++;
    end
    checks += 5;
    if (acc !== 4)             begin failures++; $display("FAIL full accepted: got %0d want 4", acc); end
    if (seen !== 4)            begin failures++; $display("FAIL full emitted: got %0d want 4", seen); end
    if (s_done !== 1'b1)       begin failures++; $display("FAIL full done: got %b want 1", s_done); end
    if (s_count !== 3'd4)      begin failures++; $display("FAIL full count: got %0d want 4", s_count); end
    if ((in_valid && s_in_ready) !== 1'b0) begin failures++; $display("FAIL full 5th accept: got %b want 0", s_in_ready); end
    do_start();
    @(posedge clk); #1;
    drive(mk(2, 3, 4, 5, 0, 0, 0), 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (s_out_valid !== 1'b1) begin failures++; $display("FAIL full restart valid: got %b want 1", s_out_valid); end
    if (s_out_addr !== '0)    begin failures++; $display("FAIL full restart addr: got %0d want 0", s_out_addr); end
  endtask

  task automatic test_reset_midflight();
    do_start();
    @(posedge clk); #1;
    drive(mk(4, 5, 6, 7, 0, 0, 0), 1'b1); out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
    if (out_instr !== 32'h0) begin failures++; $display("FAIL midreset out_instr: got %h want 0", out_instr); end
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL midreset in_ready: got %b want 0", in_ready); end
    if (count !== '0)       begin failures++; $display("FAIL midreset count: got %0d want 0", count); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_mul();
    test_random();
    test_full();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
